// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op and state
// encodings, the iteration count and a 64-bit conditional negate helper.
package mdu_seq_pkg;

   localparam int unsigned MDU_ITER = 32;

   localparam logic [1:0] MDU_MULTU = 2'b00;
   localparam logic [1:0] MDU_MULT  = 2'b01;
   localparam logic [1:0] MDU_DIVU  = 2'b10;
   localparam logic [1:0] MDU_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
      return en ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_seq_neg32.sv
// 32-bit two's-complement conditional negator, used for operand magnitudes
// and for the quotient/remainder sign fix.
module neg32 (
   input  logic [31:0] a_i,
   input  logic        en_i,
   output logic [31:0] y_o
);

   assign y_o = en_i ? (~a_i + 32'd1) : a_i;

endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit writing a HI/LO register pair through a
// Start/Busy/Done handshake; 32 shift-add or restoring-divide iterations plus a sign-fix step.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       Op,
   input  logic             Start,
   input  logic             WeHi,
   input  logic             WeLo,
   input  logic [WIDTH-1:0] Wd,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   mdu_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div0_q, div0_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        sign_a_s, sign_b_s;
   logic [31:0] abs_a_s, abs_b_s;
   logic [32:0] mul_sum_s;
   logic [63:0] mul_next_s;
   logic [32:0] div_shift_s;
   logic [33:0] div_diff_s;
   logic [63:0] div_next_s;
   logic [63:0] prod_s;
   logic [31:0] quo_fix_s, rem_fix_s;
   logic        div_unused_s;

   assign sign_a_s = A[31] & Op[0];
   assign sign_b_s = B[31] & Op[0];

   neg32 u_abs_a (.a_i(A), .en_i(sign_a_s), .y_o(abs_a_s));
   neg32 u_abs_b (.a_i(B), .en_i(sign_b_s), .y_o(abs_b_s));

   // The accumulator holds {partial, operand}: product bits or {remainder, quotient}.
   assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next_s = {mul_sum_s, acc_q[31:1]};

   assign div_shift_s  = {acc_q[63:32], acc_q[31]};
   assign div_diff_s   = {1'b0, div_shift_s} - {2'b00, opnd_q};
   assign div_next_s   = div_diff_s[33] ? {div_shift_s[31:0], acc_q[30:0], 1'b0}
                                        : {div_diff_s[31:0], acc_q[30:0], 1'b1};
   assign div_unused_s = div_diff_s[32];

   assign prod_s = neg64(acc_q, neg_res_q);

   neg32 u_quo_fix (.a_i(acc_q[31:0]),  .en_i(neg_res_q), .y_o(quo_fix_s));
   neg32 u_rem_fix (.a_i(acc_q[63:32]), .en_i(neg_rem_q), .y_o(rem_fix_s));

   // Next-state, datapath and handshake logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d   = ST_CALC;
               busy_d    = 1'b1;
               cnt_d     = 5'd0;
               op_d      = Op;
               opnd_d    = Op[1] ? abs_b_s : abs_a_s;
               acc_d     = {32'd0, (Op[1] ? abs_a_s : abs_b_s)};
               neg_res_d = sign_a_s ^ sign_b_s;
               neg_rem_d = sign_a_s;
               div0_d    = (B == 32'd0);
            end else begin
               hi_d = WeHi ? Wd : hi_q;
               lo_d = WeLo ? Wd : lo_q;
            end
         end
         ST_CALC: begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + 5'd1;
            acc_d  = op_q[1] ? div_next_s : mul_next_s;
            if (cnt_q == 5'(MDU_ITER - 1)) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (op_q[1]) begin
               hi_d = rem_fix_s;
               lo_d = div0_q ? 32'hFFFF_FFFF : quo_fix_s;
            end else begin
               hi_d = prod_s[63:32];
               lo_d = prod_s[31:0];
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         op_q      <= 2'b00;
         opnd_q    <= 32'd0;
         acc_q     <= 64'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: results, latency, handshake,
// ignored inputs while busy, mid-operation reset and IDLE HI/LO writes.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        reset, Start, WeHi, WeLo;
   logic [31:0] A, B, Wd;
   logic [1:0]  Op;
   logic        Busy, Done;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mdu_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Start(Start),
      .WeHi(WeHi), .WeLo(WeLo), .Wd(Wd), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Op = op; A = a; B = b; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
   endtask

   // Counts edges after the Start edge until Done, bounded at 100.
   task automatic wait_done(output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      while (Done !== 1'b1 && n < 100) begin
         if (Busy === 1'b1) busy_n++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++;
      if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", HI, LO); end
      checks++;
   endtask

   task automatic test_multu();
      int n, bn;
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n, bn);
      if (n !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", n); end
      checks++;
      if (bn !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bn); end
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done: got %b expected 0", Busy); end
      checks++;
      if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
         errors++; $display("FAIL multu_result: got %h/%h expected fffffffe/00000001", HI, LO);
      end
      checks++;
      @(negedge clk);
      if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", Done); end
      checks++;
      start_op(2'b00, 32'h1234_5678, 32'h0000_0010);
      wait_done(n, bn);
      if (HI !== 32'h0000_0001 || LO !== 32'h2345_6780) begin
         errors++; $display("FAIL multu_shift: got %h/%h expected 00000001/23456780", HI, LO);
      end
      checks++;
   endtask

   task automatic test_mult();
      int n, bn;
      start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
      wait_done(n, bn);
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
         errors++; $display("FAIL mult_neg: got %h/%h expected ffffffff/ffffffeb", HI, LO);
      end
      checks++;
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n, bn);
      if (HI !== 32'd0 || LO !== 32'd1) begin
         errors++; $display("FAIL mult_negneg: got %h/%h expected 00000000/00000001", HI, LO);
      end
      checks++;
   endtask

   task automatic test_div();
      int n, bn;
      start_op(2'b10, 32'd100, 32'd7);
      wait_done(n, bn);
      if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL divu: got q=%h r=%h expected 0000000e/00000002", LO, HI); end
      checks++;
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, bn);
      if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_negdividend: got q=%h r=%h expected fffffffd/ffffffff", LO, HI);
      end
      checks++;
      start_op(2'b11, 32'd7, 32'hFFFF_FFFE);
      wait_done(n, bn);
      if (LO !== 32'hFFFF_FFFD || HI !== 32'd1) begin
         errors++; $display("FAIL div_negdivisor: got q=%h r=%h expected fffffffd/00000001", LO, HI);
      end
      checks++;
      start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, bn);
      if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
         errors++; $display("FAIL div_overflow: got q=%h r=%h expected 80000000/00000000", LO, HI);
      end
      checks++;
   endtask

   task automatic test_div_zero();
      int n, bn;
      for (int k = 0; k < 2; k++) begin
         start_op((k == 0) ? 2'b10 : 2'b11, 32'h1234_5678, 32'd0);
         wait_done(n, bn);
         if (n !== 33) begin errors++; $display("FAIL divzero_latency[%0d]: got %0d expected 33", k, n); end
         checks++;
         if (LO !== 32'hFFFF_FFFF || HI !== 32'h1234_5678) begin
            errors++; $display("FAIL divzero[%0d]: got q=%h r=%h expected ffffffff/12345678", k, LO, HI);
         end
         checks++;
      end
   endtask

   task automatic test_ignore_busy();
      int n, bn;
      start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
      repeat (5) @(negedge clk);
      Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7; WeLo = 1'b1; Wd = 32'hDEAD_BEEF;
      @(negedge clk);
      Start = 1'b0; WeLo = 1'b0;
      wait_done(n, bn);
      if (n + 6 !== 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", n + 6); end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
         errors++; $display("FAIL ignore_result: got %h/%h expected ffffffff/ffffffeb", HI, LO);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int done_seen;
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         errors++; $display("FAIL midreset_hs: got busy=%b done=%b expected 0/0", Busy, Done);
      end
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL midreset_hilo: got %h/%h expected 0/0", HI, LO); end
      checks++;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done === 1'b1 || Busy === 1'b1) done_seen++;
      end
      if (done_seen !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", done_seen); end
      checks++;
   endtask

   task automatic test_back_to_back();
      int n, bn;
      start_op(2'b00, 32'd6, 32'd7);
      wait_done(n, bn);
      if (HI !== 32'd0 || LO !== 32'd42) begin errors++; $display("FAIL b2b_first: got %h/%h expected 0/0000002a", HI, LO); end
      checks++;
      Op = 2'b10; A = 32'd100; B = 32'd7; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", Busy, Done);
      end
      checks++;
      wait_done(n, bn);
      if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
      checks++;
      if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL b2b_second: got q=%h r=%h expected 0000000e/00000002", LO, HI); end
      checks++;
   endtask

   task automatic test_idle_write();
      int n, bn;
      @(negedge clk);
      WeHi = 1'b1; Wd = 32'd5;
      @(negedge clk);
      WeHi = 1'b0;
      if (HI !== 32'd5 || LO !== 32'd14) begin errors++; $display("FAIL wr_hi: got %h/%h expected 00000005/0000000e", HI, LO); end
      checks++;
      WeHi = 1'b1; WeLo = 1'b1; Wd = 32'h0000_00AA;
      @(negedge clk);
      WeHi = 1'b0; WeLo = 1'b0;
      if (HI !== 32'hAA || LO !== 32'hAA) begin errors++; $display("FAIL wr_both: got %h/%h expected 000000aa/000000aa", HI, LO); end
      checks++;
      Op = 2'b00; A = 32'd2; B = 32'd3; Start = 1'b1; WeLo = 1'b1; Wd = 32'h77;
      @(negedge clk);
      Start = 1'b0; WeLo = 1'b0;
      if (LO !== 32'hAA) begin errors++; $display("FAIL wr_start_priority: got %h expected 000000aa", LO); end
      checks++;
      wait_done(n, bn);
      if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("FAIL wr_then_op: got %h/%h expected 0/00000006", HI, LO); end
      checks++;
   endtask

   initial begin
      reset = 1'b0; Start = 1'b0; WeHi = 1'b0; WeLo = 1'b0;
      A = 32'd0; B = 32'd0; Wd = 32'd0; Op = 2'b00;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      test_idle_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Sequential multiply/divide unit for the multi-cycle CPU datapath, implementing MIPS-style MULT, MULTU, DIV and DIVU into a dedicated HI/LO register pair. It sits in the execute stage beside the ALU. HI and LO feed the 32-bit 2:1 writeback selector that serves MFHI/MFLO. The control unit issues operations through a Start/Busy/Done handshake.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width. Only 32 is supported.

Ports:
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `A` input, 32 bits: multiplicand or dividend.
- `B` input, 32 bits: multiplier or divisor.
- `Op` input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `Start` input, 1 bit: begin the operation; sampled only in IDLE.
- `WeHi` input, 1 bit: MTHI write enable; honoured only in IDLE.
- `WeLo` input, 1 bit: MTLO write enable; honoured only in IDLE.
- `Wd` input, 32 bits: MTHI/MTLO write data.
- `Busy` output, 1 bit: an operation is in progress.
- `Done` output, 1 bit: one-cycle pulse; HI/LO hold the new result.
- `HI` output, 32 bits: high product word, or remainder.
- `LO` output, 32 bits: low product word, or quotient.

## Operation
- FSM states:
  - IDLE → CALC when `Start`=1.
  - CALC runs 32 iterations, then → FIX.
  - FIX → IDLE, writing HI/LO.
- Start edge in IDLE:
  - latch `Op`, |A| and |B| (absolute values for signed ops, raw values for unsigned);
  - latch result signs;
  - clear the 5-bit iteration counter.
- Multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle, 33-bit partial-remainder subtract.
- FIX step:
  - signed MULT: negate the 64-bit product if A and B signs differ;
  - signed DIV: negate the quotient if signs differ; give the remainder the dividend's sign (truncate toward zero).
- Divide by zero, both DIV and DIVU: LO=32'hFFFFFFFF, HI=A. Latency is unchanged.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0. This falls out of unsigned magnitudes with no special case.
- `Start` in a non-IDLE state is ignored, and A/B/Op changes mid-operation have no effect.
- `WeHi`/`WeLo` in IDLE write `Wd` to HI/LO at the next edge.
  - Both high: both registers are written.
  - `Start` in the same cycle has priority, and the writes are dropped.
  - While `Busy`=1 the writes are ignored.
- HI/LO change only on a FIX completion, an IDLE write, or reset.

## Timing
- Reset edge: state=IDLE, `Busy`=0, `Done`=0, HI=0, LO=0, counter=0.
- Reset mid-operation aborts the operation with the same values, and no `Done` is produced.
- Start sampled at edge E0:
  - `Busy`=1 after edges E0 through E32 (33 cycles);
  - FIX executes at E33, and HI/LO take the result at E33;
  - `Done`=1 and `Busy`=0 for the one cycle after E33.
- `Done` and `Busy` are registered, never combinational from `Start`.
- `Start` asserted during the `Done` cycle is accepted at that edge, giving back-to-back operation with no dead cycle.
- HI/LO are registered outputs with zero combinational path from inputs.

## Structure
- Shared include `mdu_defs.vh` holds:
  - Op encodings (`MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`);
  - state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2);
  - the iteration count constant 32.
- One natural sub-module is `neg32`, a 32-bit two's-complement conditional negator (input, enable → output). It is instantiated for operand absolute values and for quotient/remainder sign fix. The 64-bit product negate uses two instances with a carry chain or is written inline.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001; `Done` exactly 33 edges after the Start edge; `Busy` high for 33 cycles.
- MULT A=32'hFFFFFFFD (−3), B=7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. DIVU A=100, B=7 → LO=14, HI=2.
- DIV A=−7, B=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV A=32'h80000000, B=32'hFFFFFFFF → LO=32'h80000000, HI=0.
- DIVU and DIV with A=32'h12345678, B=0 → LO=32'hFFFFFFFF, HI=32'h12345678 after normal latency.
- Ignored inputs during an operation:
  - `Start` pulsed again at cycle 5 of a MULT is ignored;
  - WeLo=1, Wd=32'hDEADBEEF during `Busy` is ignored;
  - the final result matches the first operation.
- Reset at cycle 10 of a DIV → next cycle `Busy`=0, `Done`=0, HI=LO=0.
- Back-to-back: `Start` in the `Done` cycle begins a new operation.
- IDLE write: WeHi=1 with Wd=5 → HI=5 next cycle.
